// File: rtl/swd_target_phy.sv
// SWD target line PHY: oversamples SWDCLK, decodes packet headers, drives
// ACK / read data / parity, captures write data and hands requests to a
// DP/AP register backend over a valid/response handshake.
module swd_target_phy #(
   parameter int unsigned LINE_RESET_ONES = 50,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic        CLK,
   input  logic        PORESETn,
   input  logic        SWDCLK,
   input  logic        SWDIN,
   output logic        SWDOUT,
   output logic        SWDOE,
   output logic        req_valid,
   output logic        req_apndp,
   output logic        req_rnw,
   output logic [1:0]  req_addr,
   input  logic        rsp_valid,
   input  logic [2:0]  rsp_ack,
   input  logic [31:0] rsp_rdata,
   output logic        wr_valid,
   output logic [31:0] wr_data,
   output logic        wr_perr,
   output logic        line_reset
);

   localparam int unsigned ONES_W = $clog2(LINE_RESET_ONES + 1);
   localparam int unsigned CNT_W  = 5;
   localparam logic [2:0]  ACK_OK   = 3'b001;
   localparam logic [2:0]  ACK_WAIT = 3'b010;

   typedef enum logic [3:0] {
      LOCKED, IDLE, HDR, TRN1, ACK, RDATA, RPAR, TRNE, TRN2W, WDATA, WPAR
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] din_sync;
   logic                   clk_prev;
   logic [ONES_W-1:0]      ones_cnt;
   logic                   lr_armed;
   logic [CNT_W-1:0]       bit_cnt;
   logic [5:0]             hdr_sr;
   logic                   rsp_seen;
   logic [2:0]             ack_q;
   logic [31:0]            rdata_q;
   logic                   rpar_q;
   logic [31:0]            wdata_sr;

   logic                   din_c;
   logic                   rise_c;
   logic                   lr_hit_c;
   logic [6:0]             hdr_full_c;
   logic                   hdr_ok_c;
   logic [2:0]             ack_eff_c;
   logic [31:0]            rdata_eff_c;

   // Bring SWDCLK and SWDIN into the CLK domain and keep the previous clock level
   always_ff @(posedge CLK) begin
      if (!PORESETn) begin
         clk_sync <= '0;
         din_sync <= '0;
         clk_prev <= 1'b0;
      end else begin
         clk_sync <= SYNC_STAGES'({clk_sync, SWDCLK});
         din_sync <= SYNC_STAGES'({din_sync, SWDIN});
         clk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign din_c    = din_sync[SYNC_STAGES-1];
   assign rise_c   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
   // The rise that brings the ones count to its threshold is the line reset
   assign lr_hit_c = rise_c & ~SWDOE & din_c &
                     (ones_cnt == ONES_W'(LINE_RESET_ONES - 1));

   // Header as seen at the park bit: [0]APnDP [1]RnW [2]A2 [3]A3 [4]par [5]stop [6]park
   assign hdr_full_c = {din_c, hdr_sr};
   assign hdr_ok_c   = ~(^hdr_full_c[4:0]) & ~hdr_full_c[5] & hdr_full_c[6];

   // Response in effect at the TRN1 rise: the latched one, or one arriving right now
   assign ack_eff_c   = rsp_seen ? ack_q   : (rsp_valid ? rsp_ack   : ACK_WAIT);
   assign rdata_eff_c = rsp_seen ? rdata_q : (rsp_valid ? rsp_rdata : 32'h0);

   // Protocol FSM: line-reset detection, header decode, ACK/data phases
   always_ff @(posedge CLK) begin
      if (!PORESETn) begin
         state      <= LOCKED;
         SWDOUT     <= 1'b0;
         SWDOE      <= 1'b0;
         req_valid  <= 1'b0;
         req_apndp  <= 1'b0;
         req_rnw    <= 1'b0;
         req_addr   <= 2'b00;
         wr_valid   <= 1'b0;
         wr_data    <= 32'h0;
         wr_perr    <= 1'b0;
         line_reset <= 1'b0;
         ones_cnt   <= '0;
         lr_armed   <= 1'b0;
         bit_cnt    <= '0;
         hdr_sr     <= '0;
         rsp_seen   <= 1'b0;
         ack_q      <= 3'b000;
         rdata_q    <= 32'h0;
         rpar_q     <= 1'b0;
         wdata_sr   <= 32'h0;
      end else begin
         req_valid  <= 1'b0;
         wr_valid   <= 1'b0;
         line_reset <= 1'b0;

         // Keep only the first response offered while waiting for TRN1
         if (state == TRN1 && rsp_valid && !rsp_seen) begin
            rsp_seen <= 1'b1;
            ack_q    <= rsp_ack;
            rdata_q  <= rsp_rdata;
         end

         if (rise_c) begin
            if (!SWDOE) begin
               if (!din_c)
                  ones_cnt <= '0;
               else if (ones_cnt < ONES_W'(LINE_RESET_ONES))
                  ones_cnt <= ones_cnt + ONES_W'(1);
            end

            if (lr_hit_c) begin
               line_reset <= 1'b1;
               lr_armed   <= 1'b1;
               state      <= LOCKED;
               SWDOE      <= 1'b0;
               SWDOUT     <= 1'b0;
            end else begin
               case (state)
                  LOCKED: begin
                     SWDOE  <= 1'b0;
                     SWDOUT <= 1'b0;
                     if (!din_c && lr_armed) begin
                        lr_armed <= 1'b0;
                        state    <= IDLE;
                     end
                  end
                  IDLE: begin
                     SWDOE  <= 1'b0;
                     SWDOUT <= 1'b0;
                     if (din_c) begin
                        bit_cnt <= '0;
                        state   <= HDR;
                     end
                  end
                  HDR: begin
                     if (bit_cnt == CNT_W'(6)) begin
                        if (hdr_ok_c) begin
                           req_valid <= 1'b1;
                           req_apndp <= hdr_full_c[0];
                           req_rnw   <= hdr_full_c[1];
                           req_addr  <= {hdr_full_c[3], hdr_full_c[2]};
                           rsp_seen  <= 1'b0;
                           state     <= TRN1;
                        end else begin
                           state <= LOCKED;
                        end
                     end else begin
                        hdr_sr  <= {din_c, hdr_sr[5:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
                  TRN1: begin
                     SWDOE   <= 1'b0;
                     ack_q   <= ack_eff_c;
                     rdata_q <= rdata_eff_c;
                     rpar_q  <= ^rdata_eff_c;
                     bit_cnt <= '0;
                     state   <= ACK;
                  end
                  ACK: begin
                     SWDOE  <= 1'b1;
                     SWDOUT <= ack_q[bit_cnt[1:0]];
                     if (bit_cnt == CNT_W'(2)) begin
                        bit_cnt <= '0;
                        if (ack_q == ACK_OK)
                           state <= req_rnw ? RDATA : TRN2W;
                        else
                           state <= TRNE;
                     end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                     end
                  end
                  RDATA: begin
                     SWDOE   <= 1'b1;
                     SWDOUT  <= rdata_q[0];
                     rdata_q <= {1'b0, rdata_q[31:1]};
                     if (bit_cnt == CNT_W'(31))
                        state <= RPAR;
                     else
                        bit_cnt <= bit_cnt + CNT_W'(1);
                  end
                  RPAR: begin
                     SWDOE  <= 1'b1;
                     SWDOUT <= rpar_q;
                     state  <= TRNE;
                  end
                  TRNE: begin
                     SWDOE  <= 1'b0;
                     SWDOUT <= 1'b0;
                     state  <= IDLE;
                  end
                  TRN2W: begin
                     SWDOE   <= 1'b0;
                     SWDOUT  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= WDATA;
                  end
                  WDATA: begin
                     wdata_sr <= {din_c, wdata_sr[31:1]};
                     if (bit_cnt == CNT_W'(31))
                        state <= WPAR;
                     else
                        bit_cnt <= bit_cnt + CNT_W'(1);
                  end
                  WPAR: begin
                     wr_valid <= 1'b1;
                     wr_data  <= wdata_sr;
                     wr_perr  <= din_c ^ (^wdata_sr);
                     state    <= IDLE;
                  end
                  default: begin
                     SWDOE <= 1'b0;
                     state <= LOCKED;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_swd_target_phy.sv
// Bench for swd_target_phy: bit-bangs a host SWD master and checks wire
// responses, backend requests and write captures against hand-made vectors.
module tb_swd_target_phy;

   logic        CLK;
   logic        PORESETn;
   logic        SWDCLK;
   logic        SWDIN;
   logic        SWDOUT;
   logic        SWDOE;
   logic        req_valid;
   logic        req_apndp;
   logic        req_rnw;
   logic [1:0]  req_addr;
   logic        rsp_valid;
   logic [2:0]  rsp_ack;
   logic [31:0] rsp_rdata;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_perr;
   logic        line_reset;

   swd_target_phy #(.LINE_RESET_ONES(50), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .PORESETn(PORESETn), .SWDCLK(SWDCLK), .SWDIN(SWDIN),
      .SWDOUT(SWDOUT), .SWDOE(SWDOE),
      .req_valid(req_valid), .req_apndp(req_apndp), .req_rnw(req_rnw),
      .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
      .rsp_rdata(rsp_rdata), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_perr(wr_perr), .line_reset(line_reset)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string       name;
      logic [7:0]  hdr;
      logic        rsp_en;
      int          dly;
      logic [2:0]  ack;
      logic        twice;
      logic [2:0]  ack2;
      logic [31:0] data;
      logic        flip;
      logic        exp_req;
      logic [2:0]  exp_ack;
   } vec_t;

   int n_checks = 0;
   int n_err    = 0;
   int n_req    = 0;
   int n_wr     = 0;
   int n_lr     = 0;
   logic        cap_apndp, cap_rnw, cap_perr;
   logic [1:0]  cap_addr;
   logic [31:0] cap_wdata;

   // backend configuration, written only by the main test
   logic        cfg_en = 1'b0;
   int          cfg_dly = 2;
   logic [2:0]  cfg_ack = 3'b001;
   logic        cfg_twice = 1'b0;
   logic [2:0]  cfg_ack2 = 3'b001;
   logic [31:0] cfg_data = 32'h0;

   // Pulse monitors
   always @(posedge CLK) begin
      if (req_valid) begin
         n_req     <= n_req + 1;
         cap_apndp <= req_apndp;
         cap_rnw   <= req_rnw;
         cap_addr  <= req_addr;
      end
      if (wr_valid) begin
         n_wr      <= n_wr + 1;
         cap_wdata <= wr_data;
         cap_perr  <= wr_perr;
      end
      if (line_reset) n_lr <= n_lr + 1;
   end

   // Backend model: answers each request after cfg_dly CLKs
   initial begin
      rsp_valid = 1'b0;
      rsp_ack   = 3'b000;
      rsp_rdata = 32'h0;
      forever begin
         @(posedge CLK);
         if (req_valid && cfg_en) begin
            repeat (cfg_dly) @(negedge CLK);
            rsp_valid = 1'b1;
            rsp_ack   = cfg_ack;
            rsp_rdata = cfg_data;
            @(negedge CLK);
            rsp_valid = 1'b0;
            if (cfg_twice) begin
               @(negedge CLK);
               rsp_valid = 1'b1;
               rsp_ack   = cfg_ack2;
               rsp_rdata = ~cfg_data;
               @(negedge CLK);
               rsp_valid = 1'b0;
            end
            rsp_ack   = 3'b000;
            rsp_rdata = 32'h0;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One SWDCLK period: drive bit while low, sample target at end of high phase
   task automatic swd_bit(input logic b, output logic o, output logic oe);
      SWDIN  = b;
      SWDCLK = 1'b0;
      repeat (4) @(negedge CLK);
      SWDCLK = 1'b1;
      repeat (4) @(negedge CLK);
      o  = SWDOUT;
      oe = SWDOE;
   endtask

   task automatic idle_bits(input string name, input int n);
      logic o, oe, oe_any;
      oe_any = 1'b0;
      for (int i = 0; i < n; i++) begin
         swd_bit(1'b0, o, oe);
         oe_any |= oe;
      end
      chk({name, "/idle_oe"}, 32'(oe_any), 32'd0);
   endtask

   task automatic line_reset_seq();
      logic o, oe;
      int   l0;
      l0 = n_lr;
      for (int i = 0; i < 49; i++) swd_bit(1'b1, o, oe);
      chk("lr/before_50", 32'(n_lr - l0), 32'd0);
      swd_bit(1'b1, o, oe);
      chk("lr/at_50", 32'(n_lr - l0), 32'd1);
      for (int i = 0; i < 6; i++) swd_bit(1'b1, o, oe);
      chk("lr/after_56", 32'(n_lr - l0), 32'd1);
      chk("lr/oe", 32'(oe), 32'd0);
      idle_bits("lr", 2);
   endtask

   task automatic xfer(input vec_t v);
      logic        o, oe, oe_any, oe_all, rp, rnw;
      logic [2:0]  wack;
      logic [31:0] rd;
      int          r0, w0;
      cfg_en    = v.rsp_en;
      cfg_dly   = v.dly;
      cfg_ack   = v.ack;
      cfg_twice = v.twice;
      cfg_ack2  = v.ack2;
      cfg_data  = v.data;
      r0 = n_req;
      w0 = n_wr;
      rnw = v.hdr[2];
      oe_any = 1'b0;
      for (int i = 0; i < 8; i++) begin
         swd_bit(v.hdr[i], o, oe);
         oe_any |= oe;
      end
      chk({v.name, "/req_count"}, 32'(n_req - r0), 32'(v.exp_req));
      chk({v.name, "/hdr_oe"}, 32'(oe_any), 32'd0);
      if (!v.exp_req) begin
         idle_bits(v.name, 3);
         return;
      end
      chk({v.name, "/req_fields"}, {28'd0, cap_apndp, cap_rnw, cap_addr},
          {28'd0, v.hdr[1], v.hdr[2], v.hdr[4], v.hdr[3]});
      swd_bit(1'b0, o, oe);
      chk({v.name, "/trn1_oe"}, 32'(oe), 32'd0);
      oe_all = 1'b1;
      for (int i = 0; i < 3; i++) begin
         swd_bit(1'b0, o, oe);
         wack[i] = o;
         oe_all &= oe;
      end
      chk({v.name, "/ack_wire"}, 32'(wack), 32'(v.exp_ack));
      chk({v.name, "/ack_oe"}, 32'(oe_all), 32'd1);
      if (v.exp_ack == 3'b001 && rnw) begin
         for (int i = 0; i < 32; i++) begin
            swd_bit(1'b0, o, oe);
            rd[i] = o;
            oe_all &= oe;
         end
         swd_bit(1'b0, rp, oe);
         oe_all &= oe;
         chk({v.name, "/rdata"}, rd, v.data);
         chk({v.name, "/rparity"}, 32'(rp), 32'(^v.data));
         chk({v.name, "/rdata_oe"}, 32'(oe_all), 32'd1);
      end
      swd_bit(1'b0, o, oe);
      chk({v.name, "/trn_oe"}, 32'(oe), 32'd0);
      if (v.exp_ack == 3'b001 && !rnw) begin
         for (int i = 0; i < 32; i++) swd_bit(v.data[i], o, oe);
         swd_bit((^v.data) ^ v.flip, o, oe);
         chk({v.name, "/wr_count"}, 32'(n_wr - w0), 32'd1);
         chk({v.name, "/wr_data"}, cap_wdata, v.data);
         chk({v.name, "/wr_perr"}, 32'(cap_perr), 32'(v.flip));
      end else begin
         chk({v.name, "/no_wr"}, 32'(n_wr - w0), 32'd0);
      end
      idle_bits(v.name, 2);
   endtask

   function automatic vec_t mk(input string nm, input logic [7:0] hdr, input logic en,
                               input int dly, input logic [2:0] ack, input logic twice,
                               input logic [2:0] ack2, input logic [31:0] data,
                               input logic flip, input logic ereq, input logic [2:0] eack);
      vec_t v;
      v.name = nm; v.hdr = hdr; v.rsp_en = en; v.dly = dly; v.ack = ack;
      v.twice = twice; v.ack2 = ack2; v.data = data; v.flip = flip;
      v.exp_req = ereq; v.exp_ack = eack;
      return v;
   endfunction

   vec_t vecs [8];
   vec_t v_locked;

   initial begin
      vecs[0] = mk("rd_dp0_ok",    8'hA5, 1'b1,  2, 3'b001, 1'b0, 3'b000, 32'h2BA01477, 1'b0, 1'b1, 3'b001);
      vecs[1] = mk("wr_ap1_ok",    8'h8B, 1'b1,  2, 3'b001, 1'b0, 3'b000, 32'h23000052, 1'b0, 1'b1, 3'b001);
      vecs[2] = mk("wr_ap1_perr",  8'h8B, 1'b1,  2, 3'b001, 1'b0, 3'b000, 32'h23000052, 1'b1, 1'b1, 3'b001);
      vecs[3] = mk("rd_late_wait", 8'hA5, 1'b1, 20, 3'b001, 1'b0, 3'b000, 32'hCAFEF00D, 1'b0, 1'b1, 3'b010);
      vecs[4] = mk("rd_ap3_fault", 8'h9F, 1'b1,  2, 3'b100, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b1, 3'b100);
      vecs[5] = mk("rd_dp2_first", 8'h95, 1'b1,  2, 3'b010, 1'b1, 3'b001, 32'h12345678, 1'b0, 1'b1, 3'b010);
      vecs[6] = mk("rd_dp1_odd",   8'h8D, 1'b1,  3, 3'b001, 1'b0, 3'b000, 32'h00000007, 1'b0, 1'b1, 3'b001);
      vecs[7] = mk("wr_no_rsp",    8'h8B, 1'b0,  2, 3'b001, 1'b0, 3'b000, 32'hFFFF0000, 1'b0, 1'b1, 3'b010);
      v_locked = mk("locked_rd",   8'hA5, 1'b1,  2, 3'b001, 1'b0, 3'b000, 32'h2BA01477, 1'b0, 1'b0, 3'b000);

      PORESETn = 1'b0;
      SWDCLK   = 1'b0;
      SWDIN    = 1'b0;
      repeat (5) @(negedge CLK);
      chk("reset/SWDOE", 32'(SWDOE), 32'd0);
      chk("reset/SWDOUT", 32'(SWDOUT), 32'd0);
      chk("reset/pulses", {29'd0, req_valid, wr_valid, line_reset}, 32'd0);
      chk("reset/wr_data", wr_data, 32'd0);
      chk("reset/req", {28'd0, req_apndp, req_rnw, req_addr}, 32'd0);
      PORESETn = 1'b1;
      repeat (3) @(negedge CLK);

      // Without a line reset the target stays locked
      xfer(v_locked);

      line_reset_seq();

      for (int i = 0; i < 8; i++) xfer(vecs[i]);

      // Bad header parity: silent, then locked until line reset + idle
      xfer(mk("bad_par", 8'hAD, 1'b1, 2, 3'b001, 1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 3'b000));
      xfer(v_locked);
      line_reset_seq();
      xfer(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
